// File: rtl/grid_move_writer.sv
// 3x3 tic-tac-toe board owner: cursor movement, turn alternation, win/draw
// detection, and a req/ack hand-off of each changed cell to the drawing path.
module grid_move_writer (
   input  logic        clock,
   input  logic        resetn,
   input  logic        key_up,
   input  logic        key_down,
   input  logic        key_left,
   input  logic        key_right,
   input  logic        key_place,
   input  logic        key_clear,
   input  logic        draw_ack,
   output logic [17:0] grid,
   output logic [1:0]  cur_x,
   output logic [1:0]  cur_y,
   output logic        turn,
   output logic        draw_req,
   output logic [1:0]  draw_x,
   output logic [1:0]  draw_y,
   output logic        full_redraw,
   output logic        illegal,
   output logic        game_over,
   output logic [1:0]  winner,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_CHECK = 3'd2,
      S_DRAW  = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [17:0] grid_q, grid_d;
   logic [1:0]  cur_x_q, cur_x_d;
   logic [1:0]  cur_y_q, cur_y_d;
   logic [1:0]  cell_x_q, cell_x_d;
   logic [1:0]  cell_y_q, cell_y_d;
   logic        turn_q, turn_d;
   logic        full_redraw_q, full_redraw_d;
   logic        illegal_q, illegal_d;
   logic        game_over_q, game_over_d;
   logic [1:0]  winner_q, winner_d;
   logic [5:0]  keys_prev_q;

   logic [5:0]  keys, key_edge;
   logic        e_clear, e_place, e_up, e_down, e_left, e_right;
   logic [3:0]  cur_idx, cell_idx;
   logic [4:0]  cur_pos, cell_pos;
   logic        cur_occupied;
   logic [1:0]  cell_v [9];
   logic [1:0]  line_v [8];
   logic [1:0]  win_mark;
   logic        board_full;
   logic        do_clear;

   assign keys     = {key_clear, key_place, key_up, key_down, key_left, key_right};
   assign key_edge = keys & ~keys_prev_q;
   assign e_clear  = key_edge[5];
   assign e_place  = key_edge[4];
   assign e_up     = key_edge[3];
   assign e_down   = key_edge[2];
   assign e_left   = key_edge[1];
   assign e_right  = key_edge[0];

   // Cell (r,c) occupies bits [2*(3r+c) +: 2] of the packed grid.
   assign cur_idx      = 4'(cur_x_q) * 4'd3 + 4'(cur_y_q);
   assign cell_idx     = 4'(cell_x_q) * 4'd3 + 4'(cell_y_q);
   assign cur_pos      = {cur_idx, 1'b0};
   assign cell_pos     = {cell_idx, 1'b0};
   assign cur_occupied = (grid_q[cur_pos +: 2] != 2'd0);

   function automatic logic [1:0] line_mark(input logic [1:0] a, input logic [1:0] b,
                                            input logic [1:0] c);
      return ((a != 2'd0) && (a == b) && (b == c)) ? a : 2'd0;
   endfunction

   always_comb begin
      for (int i = 0; i < 9; i++) cell_v[i] = grid_q[2*i +: 2];
      line_v[0] = line_mark(cell_v[0], cell_v[1], cell_v[2]);
      line_v[1] = line_mark(cell_v[3], cell_v[4], cell_v[5]);
      line_v[2] = line_mark(cell_v[6], cell_v[7], cell_v[8]);
      line_v[3] = line_mark(cell_v[0], cell_v[3], cell_v[6]);
      line_v[4] = line_mark(cell_v[1], cell_v[4], cell_v[7]);
      line_v[5] = line_mark(cell_v[2], cell_v[5], cell_v[8]);
      line_v[6] = line_mark(cell_v[0], cell_v[4], cell_v[8]);
      line_v[7] = line_mark(cell_v[2], cell_v[4], cell_v[6]);
      win_mark   = 2'd0;
      board_full = 1'b1;
      for (int i = 0; i < 8; i++) if (win_mark == 2'd0) win_mark = line_v[i];
      for (int i = 0; i < 9; i++) if (cell_v[i] == 2'd0) board_full = 1'b0;
   end

   always_comb begin
      state_d       = state_q;
      grid_d        = grid_q;
      cur_x_d       = cur_x_q;
      cur_y_d       = cur_y_q;
      cell_x_d      = cell_x_q;
      cell_y_d      = cell_y_q;
      turn_d        = turn_q;
      game_over_d   = game_over_q;
      winner_d      = winner_q;
      full_redraw_d = 1'b0;
      illegal_d     = 1'b0;
      do_clear      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // One action per cycle; lower-priority edges this cycle are dropped.
            if (e_clear) begin
               do_clear = 1'b1;
            end else if (e_place) begin
               if (cur_occupied) begin
                  illegal_d = 1'b1;
               end else begin
                  cell_x_d = cur_x_q;
                  cell_y_d = cur_y_q;
                  state_d  = S_WRITE;
               end
            end else if (e_up) begin
               if (cur_x_q != 2'd0) cur_x_d = cur_x_q - 2'd1;
            end else if (e_down) begin
               if (cur_x_q != 2'd2) cur_x_d = cur_x_q + 2'd1;
            end else if (e_left) begin
               if (cur_y_q != 2'd0) cur_y_d = cur_y_q - 2'd1;
            end else if (e_right) begin
               if (cur_y_q != 2'd2) cur_y_d = cur_y_q + 2'd1;
            end
         end
         S_WRITE: begin
            grid_d[cell_pos +: 2] = turn_q ? 2'd2 : 2'd1;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (win_mark != 2'd0) begin
               winner_d    = win_mark;
               game_over_d = 1'b1;
            end else if (board_full) begin
               game_over_d = 1'b1;
            end else begin
               turn_d = ~turn_q;
            end
            state_d = S_DRAW;
         end
         S_DRAW: begin
            if (draw_ack) state_d = game_over_q ? S_OVER : S_IDLE;
         end
         S_OVER: begin
            if (e_clear) do_clear = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (do_clear) begin
         grid_d        = '0;
         cur_x_d       = 2'd0;
         cur_y_d       = 2'd0;
         turn_d        = 1'b0;
         winner_d      = 2'd0;
         game_over_d   = 1'b0;
         full_redraw_d = 1'b1;
         state_d       = S_IDLE;
      end
   end

   // Key history updates in every state, so edges outside IDLE are consumed.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         grid_q        <= '0;
         cur_x_q       <= 2'd0;
         cur_y_q       <= 2'd0;
         cell_x_q      <= 2'd0;
         cell_y_q      <= 2'd0;
         turn_q        <= 1'b0;
         full_redraw_q <= 1'b0;
         illegal_q     <= 1'b0;
         game_over_q   <= 1'b0;
         winner_q      <= 2'd0;
         keys_prev_q   <= '0;
      end else begin
         state_q       <= state_d;
         grid_q        <= grid_d;
         cur_x_q       <= cur_x_d;
         cur_y_q       <= cur_y_d;
         cell_x_q      <= cell_x_d;
         cell_y_q      <= cell_y_d;
         turn_q        <= turn_d;
         full_redraw_q <= full_redraw_d;
         illegal_q     <= illegal_d;
         game_over_q   <= game_over_d;
         winner_q      <= winner_d;
         keys_prev_q   <= keys;
      end
   end

   // Valid/ready contract: draw_req and draw_x/draw_y stay stable from entry
   // into DRAW until the edge at which draw_ack is sampled high.
   assign draw_req    = (state_q == S_DRAW);
   assign draw_x      = cell_x_q;
   assign draw_y      = cell_y_q;
   assign grid        = grid_q;
   assign cur_x       = cur_x_q;
   assign cur_y       = cur_y_q;
   assign turn        = turn_q;
   assign full_redraw = full_redraw_q;
   assign illegal     = illegal_q;
   assign game_over   = game_over_q;
   assign winner      = winner_q;
   assign dbg_state   = state_q;

endmodule
